fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the 32-bit synchronous FIFO among NREQ producers.
- Uses round-robin arbitration with bounded bursts: the current winner keeps the port for up to BURST_LEN consecutive beats.
- Sits between the producer blocks and the FIFO's w_en/data_in/full pins.
- Write strobe and data are combinational from registered arbiter state, so the FIFO captures a word on the same edge the producer sees its grant.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter and its picker.
package fifo_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int STATS_W    = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  pick,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      pick  = '0;
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found      = 1'b1;
            pick[cand] = 1'b1;
            idx        = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NREQ producers.
// Optional per-requester beat counters are enabled with `define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_LEN = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*DATA_W-1:0]     req_data,
   output logic [NREQ-1:0]            gnt,
   input  logic                       fifo_full,
   output logic                       fifo_w_en,
   output logic [DATA_W-1:0]          fifo_data_in,
   output logic [$clog2(NREQ)-1:0]    owner,
   output logic                       busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NREQ*STATS_W-1:0]    beat_count
`endif
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [NREQ-1:0]  pick;
   logic [IDX_W-1:0] pick_idx;
   logic [NREQ-1:0]  gnt_c;

   rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req  (req),
      .ptr  (rr_ptr_q),
      .pick (pick),
      .idx  (pick_idx)
   );

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      gnt_c      = '0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_full && (|req)) begin
               gnt_c      = pick;
               state_d    = BURST;
               owner_d    = pick_idx;
               beat_cnt_d = CNT_W'(1);
            end
         end
         BURST: begin
            // Release hands the pointer to the next index; a full FIFO only stalls.
            if (!req[owner_q] || (beat_cnt_q == CNT_W'(BURST_LEN))) begin
               state_d  = IDLE;
               rr_ptr_d = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end else if (!fifo_full) begin
               gnt_c[owner_q] = 1'b1;
               beat_cnt_d     = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // IDLE grants combinationally from req, so the reset level itself must mask them.
   assign gnt       = rst ? gnt_c : '0;
   assign fifo_w_en = |gnt;
   assign owner     = owner_q;
   assign busy      = (state_q == BURST);

   always_comb begin
      fifo_data_in = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) fifo_data_in = fifo_data_in | req_data[i*DATA_W +: DATA_W];
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   for (genvar i = 0; i < NREQ; i++) begin : g_stat
      logic [STATS_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                    cnt_q <= '0;
         else if (gnt[i] && ~&cnt_q) cnt_q <= cnt_q + 1'b1;
      end

      assign beat_count[i*STATS_W +: STATS_W] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int DATA_W    = 32;
   localparam int BURST_LEN = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        gnt;
   logic                   fifo_full;
   logic                   fifo_w_en;
   logic [DATA_W-1:0]      fifo_data_in;
   logic [1:0]             owner;
   logic                   busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [NREQ*16-1:0]     beat_count;
`endif

   fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .fifo_full    (fifo_full),
      .fifo_w_en    (fifo_w_en),
      .fifo_data_in (fifo_data_in),
      .owner        (owner),
      .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .beat_count   (beat_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Producer queues and observation logs.
   logic [DATA_W-1:0] src_q [NREQ][$];
   logic [DATA_W-1:0] sink_q[$];
   int                gnt_log[$];
   logic              busy_log[$];
   int                owner_log[$];
   logic              full_plan;

   // Behavioural arbitration model.
   bit m_busy;
   int m_owner, m_cnt, m_ptr;

   function automatic int enc(logic [NREQ-1:0] g);
      if (g == '0) return -1;
      if (!$onehot(g)) return -2;
      for (int i = 0; i < NREQ; i++) if (g[i]) return i;
      return -2;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
   endtask

   task automatic clear_logs();
      sink_q.delete(); gnt_log.delete(); busy_log.delete(); owner_log.delete();
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NREQ; i++) begin
         req[i] = (src_q[i].size() > 0);
         req_data[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      end
      fifo_full = full_plan;
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      full_plan = 1'b0;
      drive_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clear_logs();
   endtask

   // One clock cycle: drive at the negedge, compare to the model, commit at the posedge.
   task automatic step();
      int              win;
      int              c;
      bit              n_busy;
      int              n_owner, n_cnt, n_ptr;
      logic [NREQ-1:0] exp_gnt;
      logic [DATA_W-1:0] exp_data;
      drive_inputs();
      #1;
      win = -1; n_busy = m_busy; n_owner = m_owner; n_cnt = m_cnt; n_ptr = m_ptr;
      if (!m_busy) begin
         if (!full_plan && req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
               c = (m_ptr + k) % NREQ;
               if (win < 0 && req[c]) win = c;
            end
            n_busy = 1'b1; n_owner = win; n_cnt = 1;
         end
      end else if (!req[m_owner] || m_cnt == BURST_LEN) begin
         n_busy = 1'b0; n_ptr = (m_owner + 1) % NREQ;
      end else if (!full_plan) begin
         win = m_owner; n_cnt = m_cnt + 1;
      end
      exp_gnt  = (win < 0) ? '0 : (NREQ'(1) << win);
      exp_data = (win < 0) ? '0 : src_q[win][0];

      n_checks++;
      if (gnt !== exp_gnt) begin
         n_fail++; $display("FAIL gnt: got %b expected %b at %0t", gnt, exp_gnt, $time);
      end
      n_checks++;
      if (fifo_w_en !== (exp_gnt != '0)) begin
         n_fail++; $display("FAIL fifo_w_en: got %b expected %b at %0t", fifo_w_en, exp_gnt != '0, $time);
      end
      n_checks++;
      if (fifo_data_in !== exp_data) begin
         n_fail++; $display("FAIL fifo_data_in: got %h expected %h at %0t", fifo_data_in, exp_data, $time);
      end
      n_checks++;
      if (busy !== m_busy) begin
         n_fail++; $display("FAIL busy: got %b expected %b at %0t", busy, m_busy, $time);
      end
      n_checks++;
      if (owner !== 2'(m_owner)) begin
         n_fail++; $display("FAIL owner: got %0d expected %0d at %0t", owner, m_owner, $time);
      end

      gnt_log.push_back(enc(gnt));
      busy_log.push_back(busy);
      owner_log.push_back(int'(owner));
      if (fifo_w_en) sink_q.push_back(fifo_data_in);
      if (win >= 0) void'(src_q[win].pop_front());
      m_busy = n_busy; m_owner = n_owner; m_cnt = n_cnt; m_ptr = n_ptr;
      @(negedge clk);
   endtask

   task automatic check_log(string name, int exp[]);
      n_checks++;
      if (gnt_log.size() < exp.size()) begin
         n_fail++;
         $display("FAIL %s log length: got %0d required %0d", name, gnt_log.size(), exp.size());
         return;
      end
      for (int k = 0; k < exp.size(); k++) begin
         if (gnt_log[k] != exp[k]) begin
            n_fail++;
            $display("FAIL %s grant[%0d]: got %0d required %0d", name, k, gnt_log[k], exp[k]);
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      full_plan = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         src_q[i].delete();
         src_q[i].push_back(32'h5000 + i);
      end
      drive_inputs();
      model_reset();
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(posedge clk); #1;
         n_checks++;
         if (gnt !== '0 || fifo_w_en !== 1'b0 || fifo_data_in !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b w_en=%b data=%h busy=%b required all 0",
                     gnt, fifo_w_en, fifo_data_in, busy);
         end
         @(negedge clk); #1;
         n_checks++;
         if (gnt !== '0 || fifo_w_en !== 1'b0 || fifo_data_in !== '0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_mid: got gnt=%b w_en=%b data=%h owner=%0d required 0",
                     gnt, fifo_w_en, fifo_data_in, owner);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      clear_logs();
      step();
      n_checks++;
      if (gnt_log[0] != 0) begin
         n_fail++; $display("FAIL reset_first_grant: got %0d required 0", gnt_log[0]);
      end
      repeat (8) step();
   endtask

   task automatic test_single();
      reset_dut();
      for (int k = 0; k < 8; k++) src_q[2].push_back(32'hA0 + k);
      repeat (11) step();
      check_log("single", '{2, 2, 2, 2, -1, 2, 2, 2, 2, -1, -1});
      n_checks++;
      if (sink_q.size() != 8) begin
         n_fail++; $display("FAIL single_count: got %0d required 8", sink_q.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (sink_q[k] !== 32'(32'hA0 + k)) begin
               n_fail++;
               $display("FAIL single_data[%0d]: got %h required %h", k, sink_q[k], 32'hA0 + k);
               break;
            end
         end
      end
   endtask

   task automatic test_round_robin();
      reset_dut();
      for (int i = 0; i < NREQ; i++)
         for (int j = 0; j < 2; j++) src_q[i].push_back(32'h100 * i + j);
      repeat (12) step();
      check_log("round_robin", '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1});
      n_checks++;
      if (sink_q.size() != 8) begin
         n_fail++; $display("FAIL rr_count: got %0d required 8", sink_q.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (sink_q[k] !== 32'(32'h100 * (k / 2) + (k % 2))) begin
               n_fail++;
               $display("FAIL rr_data[%0d]: got %h required %h", k, sink_q[k], 32'h100 * (k / 2) + (k % 2));
               break;
            end
         end
      end
   endtask

   task automatic test_full_stall();
      reset_dut();
      for (int k = 0; k < 4; k++) src_q[0].push_back(32'hC0 + k);
      full_plan = 1'b0; repeat (2) step();
      full_plan = 1'b1; repeat (3) step();
      full_plan = 1'b0; repeat (3) step();
      check_log("full_stall", '{0, 0, -1, -1, -1, 0, 0, -1});
      n_checks++;
      if (busy_log[2] !== 1'b1 || busy_log[3] !== 1'b1 || busy_log[4] !== 1'b1 ||
          owner_log[2] != 0 || owner_log[4] != 0) begin
         n_fail++;
         $display("FAIL stall_hold: got busy=%b%b%b owner=%0d required busy=111 owner=0",
                  busy_log[2], busy_log[3], busy_log[4], owner_log[4]);
      end
      n_checks++;
      if (sink_q.size() != 4 || sink_q[0] !== 32'hC0 || sink_q[1] !== 32'hC1 ||
          sink_q[2] !== 32'hC2 || sink_q[3] !== 32'hC3) begin
         n_fail++; $display("FAIL stall_data: got %0d words required C0..C3 in order", sink_q.size());
      end
   endtask

   task automatic test_async_reset();
      reset_dut();
      for (int k = 0; k < 4; k++) src_q[1].push_back(32'hE0 + k);
      step();
      drive_inputs();
      #1;
      n_checks++;
      if (gnt !== 4'b0010) begin
         n_fail++; $display("FAIL arst_beat2: got %b required 0010", gnt);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (gnt !== '0 || fifo_w_en !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_immediate: got gnt=%b w_en=%b busy=%b required 0", gnt, fifo_w_en, busy);
      end
      model_reset();
      src_q[0].push_back(32'hD0);
      @(negedge clk);
      drive_inputs();
      #1;
      n_checks++;
      if (gnt !== '0 || fifo_data_in !== '0) begin
         n_fail++; $display("FAIL arst_held: got gnt=%b data=%h required 0", gnt, fifo_data_in);
      end
      @(negedge clk);
      rst = 1'b1;
      clear_logs();
      repeat (8) step();
      n_checks++;
      if (gnt_log[0] != 0 || sink_q.size() == 0 || sink_q[0] !== 32'hD0) begin
         n_fail++; $display("FAIL arst_restart: got first grant %0d required 0 with data D0", gnt_log[0]);
      end
   endtask

   task automatic test_random();
      int drain;
      reset_dut();
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 3) == 0 && src_q[i].size() < 6) src_q[i].push_back($urandom);
         full_plan = ($urandom_range(0, 4) == 0);
         step();
      end
      full_plan = 1'b0;
      drain = 0;
      while (drain < 200 && (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) != 0) begin
         step();
         drain++;
      end
      n_checks++;
      if (drain >= 200) begin
         n_fail++; $display("FAIL random_drain: got queues non-empty after %0d cycles required empty", drain);
      end
   endtask

`ifdef FIFO_WR_ARB_STATS_EN
   task automatic test_stats();
      reset_dut();
      for (int k = 0; k < 5; k++) src_q[1].push_back(32'h1100 + k);
      for (int k = 0; k < 3; k++) src_q[3].push_back(32'h3300 + k);
      repeat (14) step();
      n_checks++;
      if (beat_count !== {16'd3, 16'd0, 16'd5, 16'd0}) begin
         n_fail++; $display("FAIL stats_count: got %h required 0003_0000_0005_0000", beat_count);
      end
      force dut.g_stat[1].cnt_q = 16'hFFFF;
      #1;
      release dut.g_stat[1].cnt_q;
      @(negedge clk);
      src_q[1].push_back(32'h11FF);
      repeat (4) step();
      n_checks++;
      if (beat_count[31:16] !== 16'hFFFF || beat_count[63:48] !== 16'd3) begin
         n_fail++; $display("FAIL stats_saturate: got slice1=%h slice3=%h required FFFF and 3",
                            beat_count[31:16], beat_count[63:48]);
      end
   endtask
`endif

   initial begin
      rst = 1'b0;
      req = '0;
      req_data = '0;
      fifo_full = 1'b0;
      full_plan = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_async_reset();
      test_random();
`ifdef FIFO_WR_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
